// File: rtl/adder_pkg.sv
// Shared constants and payload type for the adder pipeline.
// ADDER_PIPE_SATURATE_EN, when defined, clamps an overflowing sum to all ones.
package adder_pkg;

    localparam int DefaultWidth    = 8;
    localparam int DefaultCntWidth = 16;

    // Layout of the second pipeline stage at the default width.
    typedef struct packed {
        logic                    carry;
        logic [DefaultWidth-1:0] sum;
    } s2_payload_t;

endpackage

// File: rtl/adder_pipe_stage.sv
// One elastic pipeline register.
// It accepts new data in the same cycle it hands its current contents downstream.
module adder_pipe_stage #(
    parameter int DataWidth = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [DataWidth-1:0] data_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [DataWidth-1:0] data_o
);

    logic                 r_valid;
    logic [DataWidth-1:0] r_data;
    logic                 w_load;

    assign ready_o = !r_valid || ready_i;
    assign w_load  = valid_i && ready_o;
    assign valid_o = r_valid;
    assign data_o  = r_data;

    // Data holds when the stage is not loading, so an empty stage shows its last value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            if (w_load) begin
                r_data  <= data_i;
                r_valid <= 1'b1;
            end else if (ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/adder_pipe.sv
// Two-stage elastic adder: S1 holds the operand pair, S2 holds {carry, sum}, and the top counts handed-off results.
// ADDER_PIPE_SATURATE_EN selects saturating results instead of wrap-around.
module adder_pipe
    import adder_pkg::*;
#(
    parameter int Width    = DefaultWidth,
    parameter int CntWidth = DefaultCntWidth
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [Width-1:0]    a_i,
    input  logic [Width-1:0]    b_i,
    input  logic                valid_i,
    output logic                ready_o,
    output logic [Width-1:0]    c_o,
    output logic                carry_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [CntWidth-1:0] count_o
);

    logic                 w_s1_valid;
    logic                 w_s2_ready;
    logic [2*Width-1:0]   w_s1_data;
    logic [Width-1:0]     w_op_a;
    logic [Width-1:0]     w_op_b;
    logic [Width:0]       w_sum_ext;
    logic [Width-1:0]     w_result;
    logic [Width:0]       w_s2_data;
    logic [CntWidth-1:0]  r_count;

    adder_pipe_stage #(
        .DataWidth (2*Width)
    ) u_s1 (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  ({a_i, b_i}),
        .valid_o (w_s1_valid),
        .ready_i (w_s2_ready),
        .data_o  (w_s1_data)
    );

    assign w_op_a    = w_s1_data[2*Width-1:Width];
    assign w_op_b    = w_s1_data[Width-1:0];
    assign w_sum_ext = {1'b0, w_op_a} + {1'b0, w_op_b};

`ifdef ADDER_PIPE_SATURATE_EN
    assign w_result = w_sum_ext[Width] ? {Width{1'b1}} : w_sum_ext[Width-1:0];
`else
    assign w_result = w_sum_ext[Width-1:0];
`endif

    assign w_s2_data = {w_sum_ext[Width], w_result};

    adder_pipe_stage #(
        .DataWidth (Width+1)
    ) u_s2 (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (w_s1_valid),
        .ready_o (w_s2_ready),
        .data_i  (w_s2_data),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  ({carry_o, c_o})
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= '0;
        end else if (valid_o && ready_i) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count_o = r_count;

endmodule
